pc_seq_unit: RTL and testbench
==============================

# pc_seq_unit

Parametrised next-generation program-counter unit for the single-cycle CPU. It holds the instruction-memory address and selects the next PC from sequential, conditional-branch, jump, call, return and external redirect sources. Call/return targets come from an internal circular return-address stack (RAS). It sits between the decoder/ALU (control inputs, offsets, compare result) and the instruction memory (`IM_address`).

## Interface
Parameters:
- `ADDR_W`, 32: PC/address width.
- `RESET_VEC`, 0: PC value after reset (ADDR_W bits, must be 4-byte aligned).
- `RAS_DEPTH`, 4: return-stack entries; power of two, ≥2.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset. One clock; reset is synchronous and active-high.
- `PC_enable` in 1: advance/update enable. When 0, all state holds.
- `ctrl_kind` in 3: `pc_ctrl_t`. SEQ=0, BRANCH=1, JUMP=2, CALL=3, RET=4, REDIRECT=5. Values 6–7 are treated as SEQ.
- `imm_offset` in ADDR_W: sign-extended, already shifted byte offset for BRANCH/JUMP/CALL.
- `alu_result` in 32: compare result. `detect = |alu_result`.
- `br_on_nonzero` in 1: 0 = branch taken when detect==0; 1 = branch taken when detect==1.
- `redirect_addr` in ADDR_W: absolute target for REDIRECT.
- `IM_address` out ADDR_W: current PC.
- `link_addr` out ADDR_W: combinational `IM_address + 4`, used for register writeback on CALL.
- `ras_count` out $clog2(RAS_DEPTH)+1: valid RAS entries.
- `ras_overflow` out 1: sticky; set on a push while full.
- `ras_underflow` out 1: sticky; set on a pop while empty.
- `misalign` out 1: sticky; set when a selected target has nonzero bits [1:0].

## Operation
Next-PC selection (`pc_next`) by `ctrl_kind`:
- SEQ: PC+4.
- BRANCH: PC+imm_offset if taken, else PC+4. Taken = `detect ^ ~br_on_nonzero`.
- JUMP: PC+imm_offset.
- CALL: push `link_addr`, target PC+imm_offset.
- RET: if `ras_count`>0, pop the top entry and jump to it. If empty, PC+4 and set `ras_underflow`.
- REDIRECT: `redirect_addr`. The RAS is untouched.

Arithmetic and width rules:
- All additions are modulo 2^ADDR_W; wrap from all-ones+4 to 0 is silent.
- Every loaded target has bits [1:0] forced to 0. If the raw target had them nonzero, `misalign` is set.

RAS behaviour:
- Circular buffer with a top pointer.
- Push when full: overwrite the oldest entry, count stays RAS_DEPTH, set `ras_overflow`.
- Pop: returns the most recent push.
- CALL and RET cannot coincide, since `ctrl_kind` is a single value.

Enable and reset:
- `PC_enable`=0: PC, RAS contents, pointer, count and sticky flags all hold. Control inputs are ignored.
- `rst`=1 (takes priority over `PC_enable`):
  - `IM_address`=RESET_VEC.
  - `ras_count`=0, pointer=0.
  - All sticky flags = 0.
  - RAS entry contents are don't-care.
- Reset mid-sequence discards all stacked returns.

## Timing
- Single-cycle: the selection is combinational from the current inputs. `IM_address`, the RAS and the flags update on the posedge `clk` where `PC_enable`=1.
- Latency of one cycle from control inputs to the new `IM_address`.
- Sticky flags assert in the same edge as the offending update and stay set until `rst`.
- `link_addr` follows `IM_address` combinationally, with zero cycles of latency.
- The first edge with `rst` deasserted and `PC_enable`=1 loads `pc_next` computed from RESET_VEC.

## Structure
- Shared `pc_pkg`:
  - `pc_ctrl_t` enum.
  - `INSTR_BYTES`=4.
  - Helper function `align4`.
- Sub-module `ras_stack`, parameters `ADDR_W` and `DEPTH`:
  - Inputs `push`, `pop`, `push_data`.
  - Outputs `top_data`, `count`, `full`, `empty`.
  - Overwrite-oldest on full.
- The top level holds the PC register, mux and flags.

## Test plan
- Reset, then 3 SEQ cycles with enable=1 → `IM_address` goes 0, 4, 8, 0xC. All flags 0, `ras_count`=0.
- At PC=0x100:
  - BRANCH, imm=0x20, alu_result=0, br_on_nonzero=0 → 0x120.
  - Repeat with alu_result=5 → 0x104.
  - Repeat with br_on_nonzero=1, alu_result=5 → 0x120.
- Nested return ordering:
  - CALL at 0x10 (imm 0x100) → PC 0x110, count 1.
  - CALL at 0x110 (imm 0x40) → PC 0x150, count 2.
  - RET → 0x114.
  - RET → 0x14, count 0.
  - Third RET → 0x18, `ras_underflow`=1.
- RAS_DEPTH=4 overflow:
  - 5 CALLs → count 4, `ras_overflow`=1.
  - 4 RETs return the last four link addresses in reverse order; the first link is lost.
- Enable and reset:
  - `PC_enable`=0 with CALL presented for 3 cycles → PC and count unchanged.
  - REDIRECT to 0x203 → PC 0x200, `misalign`=1.
  - Assert `rst` → PC=RESET_VEC and all flags clear.
- Wrap: ADDR_W=32, PC=0xFFFFFFFC, SEQ → 0x00000000 with no flag set.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared types and helpers for the program-counter unit and its return stack.
package pc_pkg;

    typedef enum logic [2:0] {
        PC_SEQ      = 3'd0,
        PC_BRANCH   = 3'd1,
        PC_JUMP     = 3'd2,
        PC_CALL     = 3'd3,
        PC_RET      = 3'd4,
        PC_REDIRECT = 3'd5
    } pc_ctrl_t;

    localparam int INSTR_BYTES = 4;

    // Works on a 64-bit container so any ADDR_W up to 64 can reuse it.
    function automatic logic [63:0] align4(input logic [63:0] addr);
        return {addr[63:2], 2'b00};
    endfunction

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack; a push while full silently replaces the oldest entry.
module ras_stack #(
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [ADDR_W-1:0]          push_data,
    output logic [ADDR_W-1:0]          top_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  cnt;

    assign full     = (cnt == CNT_W'(DEPTH));
    assign empty    = (cnt == '0);
    assign count    = cnt;
    // wr_ptr names the next free slot, so the most recent push sits one below it.
    assign top_data = mem[wr_ptr - PTR_W'(1)];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            cnt    <= '0;
        end else if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
            if (!full) begin
                cnt <= cnt + CNT_W'(1);
            end
        end else if (pop && !empty) begin
            wr_ptr <= wr_ptr - PTR_W'(1);
            cnt    <= cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/pc_seq_unit.sv
// Program-counter unit: next-PC mux over sequential/branch/jump/call/return/redirect,
// backed by a circular return-address stack and sticky fault flags.
module pc_seq_unit #(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0,
    parameter int                RAS_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         PC_enable,
    input  logic [2:0]                   ctrl_kind,
    input  logic [ADDR_W-1:0]            imm_offset,
    input  logic [31:0]                  alu_result,
    input  logic                         br_on_nonzero,
    input  logic [ADDR_W-1:0]            redirect_addr,
    output logic [ADDR_W-1:0]            IM_address,
    output logic [ADDR_W-1:0]            link_addr,
    output logic [$clog2(RAS_DEPTH):0]   ras_count,
    output logic                         ras_overflow,
    output logic                         ras_underflow,
    output logic                         misalign
);

    import pc_pkg::*;

    pc_ctrl_t          kind;
    logic              detect;
    logic              taken;
    logic [ADDR_W-1:0] rel_target;
    logic [ADDR_W-1:0] raw_target;
    logic [ADDR_W-1:0] pc_next;
    logic [ADDR_W-1:0] ras_top;
    logic              ras_full;
    logic              ras_empty;
    logic              ras_push;
    logic              ras_pop;
    logic              hit_overflow;
    logic              hit_underflow;
    logic              hit_misalign;

    assign detect     = |alu_result;
    assign taken      = detect ^ ~br_on_nonzero;
    assign link_addr  = IM_address + ADDR_W'(INSTR_BYTES);
    assign rel_target = IM_address + imm_offset;

    always_comb begin
        kind          = pc_ctrl_t'(ctrl_kind);
        raw_target    = link_addr;
        ras_push      = 1'b0;
        ras_pop       = 1'b0;
        hit_overflow  = 1'b0;
        hit_underflow = 1'b0;
        case (kind)
            PC_BRANCH: begin
                if (taken) begin
                    raw_target = rel_target;
                end
            end
            PC_JUMP: begin
                raw_target = rel_target;
            end
            PC_CALL: begin
                raw_target   = rel_target;
                ras_push     = 1'b1;
                hit_overflow = ras_full;
            end
            PC_RET: begin
                if (!ras_empty) begin
                    raw_target = ras_top;
                    ras_pop    = 1'b1;
                end else begin
                    hit_underflow = 1'b1;
                end
            end
            PC_REDIRECT: begin
                raw_target = redirect_addr;
            end
            default: begin
                raw_target = link_addr;
            end
        endcase
    end

    // PC itself is always aligned, so the sequential path never raises misalign.
    assign hit_misalign = |raw_target[1:0];
    assign pc_next      = ADDR_W'(align4(64'(raw_target)));

    ras_stack #(
        .ADDR_W (ADDR_W),
        .DEPTH  (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (ras_push & PC_enable),
        .pop       (ras_pop & PC_enable),
        .push_data (link_addr),
        .top_data  (ras_top),
        .count     (ras_count),
        .full      (ras_full),
        .empty     (ras_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            IM_address    <= RESET_VEC;
            ras_overflow  <= 1'b0;
            ras_underflow <= 1'b0;
            misalign      <= 1'b0;
        end else if (PC_enable) begin
            IM_address    <= pc_next;
            ras_overflow  <= ras_overflow  | hit_overflow;
            ras_underflow <= ras_underflow | hit_underflow;
            misalign      <= misalign      | hit_misalign;
        end
    end

endmodule

// File: tb/tb_pc_seq_unit.sv
// Directed bench for pc_seq_unit with a queue-based reference model checked every cycle.
module tb_pc_seq_unit;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst;
    logic        PC_enable;
    logic [2:0]  ctrl_kind;
    logic [31:0] imm_offset;
    logic [31:0] alu_result;
    logic        br_on_nonzero;
    logic [31:0] redirect_addr;
    logic [31:0] IM_address;
    logic [31:0] link_addr;
    logic [2:0]  ras_count;
    logic        ras_overflow;
    logic        ras_underflow;
    logic        misalign;

    int checks = 0;
    int errors = 0;

    pc_seq_unit #(
        .ADDR_W    (32),
        .RESET_VEC (32'h0),
        .RAS_DEPTH (DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .PC_enable     (PC_enable),
        .ctrl_kind     (ctrl_kind),
        .imm_offset    (imm_offset),
        .alu_result    (alu_result),
        .br_on_nonzero (br_on_nonzero),
        .redirect_addr (redirect_addr),
        .IM_address    (IM_address),
        .link_addr     (link_addr),
        .ras_count     (ras_count),
        .ras_overflow  (ras_overflow),
        .ras_underflow (ras_underflow),
        .misalign      (misalign)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: return addresses kept in a plain queue, newest at the back.
    logic [31:0] m_pc;
    logic [31:0] m_ras[$];
    logic        m_ovf, m_und, m_mis;
    bit          m_valid = 1'b0;

    always @(posedge clk) begin
        logic [31:0] tgt;
        if (rst) begin
            m_pc = 32'h0;
            m_ras.delete();
            m_ovf = 1'b0;
            m_und = 1'b0;
            m_mis = 1'b0;
            m_valid = 1'b1;
        end else if (PC_enable && m_valid) begin
            tgt = m_pc + 32'd4;
            case (ctrl_kind)
                3'd1: if (br_on_nonzero ? (alu_result != 0) : (alu_result == 0))
                          tgt = m_pc + imm_offset;
                3'd2: tgt = m_pc + imm_offset;
                3'd3: begin
                    m_ras.push_back(m_pc + 32'd4);
                    if (m_ras.size() > DEPTH) begin
                        void'(m_ras.pop_front());
                        m_ovf = 1'b1;
                    end
                    tgt = m_pc + imm_offset;
                end
                3'd4: begin
                    if (m_ras.size() > 0) tgt = m_ras.pop_back();
                    else m_und = 1'b1;
                end
                3'd5: tgt = redirect_addr;
                default: tgt = m_pc + 32'd4;
            endcase
            if (tgt % 4 != 0) m_mis = 1'b1;
            m_pc = tgt - (tgt % 4);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_valid) begin
            check("cmp_pc",   IM_address, m_pc);
            check("cmp_link", link_addr, m_pc + 32'd4);
            check("cmp_cnt",  {29'd0, ras_count}, m_ras.size());
            check("cmp_ovf",  {31'd0, ras_overflow}, {31'd0, m_ovf});
            check("cmp_und",  {31'd0, ras_underflow}, {31'd0, m_und});
            check("cmp_mis",  {31'd0, misalign}, {31'd0, m_mis});
        end
    end

    task automatic step(input logic [2:0] k, input logic [31:0] imm, input logic [31:0] alu,
                        input logic bnz, input logic [31:0] rd, input logic en);
        ctrl_kind = k; imm_offset = imm; alu_result = alu;
        br_on_nonzero = bnz; redirect_addr = rd; PC_enable = en;
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(3'd0, 0, 0, 0, 0, 1'b1);
        rst = 1'b0;
    endtask

    task automatic redir(input logic [31:0] a); step(3'd5, 0, 0, 0, a, 1'b1); endtask
    task automatic call(input logic [31:0] imm); step(3'd3, imm, 0, 0, 0, 1'b1); endtask
    task automatic ret(); step(3'd4, 0, 0, 0, 0, 1'b1); endtask
    task automatic seq(); step(3'd0, 0, 0, 0, 0, 1'b1); endtask
    task automatic br(input logic [31:0] alu, input logic bnz);
        step(3'd1, 32'h20, alu, bnz, 0, 1'b1);
    endtask

    initial begin
        rst = 1'b1; PC_enable = 1'b0; ctrl_kind = 3'd0; imm_offset = 0;
        alu_result = 0; br_on_nonzero = 1'b0; redirect_addr = 0;

        do_reset();
        check("rst_pc", IM_address, 32'h0);
        check("rst_cnt", {29'd0, ras_count}, 32'd0);
        check("rst_flags", {29'd0, ras_overflow, ras_underflow, misalign}, 32'd0);
        seq(); check("seq1", IM_address, 32'h4);
        seq(); check("seq2", IM_address, 32'h8);
        seq(); check("seq3", IM_address, 32'hC);
        check("link_c", link_addr, 32'h10);

        redir(32'h100); br(32'd0, 1'b0); check("br_z_taken", IM_address, 32'h120);
        redir(32'h100); br(32'd5, 1'b0); check("br_z_not", IM_address, 32'h104);
        redir(32'h100); br(32'd5, 1'b1); check("br_nz_taken", IM_address, 32'h120);
        redir(32'h100); br(32'd0, 1'b1); check("br_nz_not", IM_address, 32'h104);
        step(3'd7, 32'h80, 0, 0, 0, 1'b1); check("kind7_seq", IM_address, 32'h108);

        do_reset();
        redir(32'h10);
        call(32'h100); check("call1_pc", IM_address, 32'h110);
        check("call1_cnt", {29'd0, ras_count}, 32'd1);
        call(32'h40);  check("call2_pc", IM_address, 32'h150);
        check("call2_cnt", {29'd0, ras_count}, 32'd2);
        ret(); check("ret1", IM_address, 32'h114);
        ret(); check("ret2", IM_address, 32'h14);
        check("ret2_cnt", {29'd0, ras_count}, 32'd0);
        ret(); check("ret3_pc", IM_address, 32'h18);
        check("ret3_und", {31'd0, ras_underflow}, 32'd1);

        do_reset();
        for (int i = 0; i < 5; i++) call(32'h10);
        check("ovf_pc", IM_address, 32'h50);
        check("ovf_cnt", {29'd0, ras_count}, 32'd4);
        check("ovf_flag", {31'd0, ras_overflow}, 32'd1);
        ret(); check("ovf_ret1", IM_address, 32'h44);
        ret(); check("ovf_ret2", IM_address, 32'h34);
        ret(); check("ovf_ret3", IM_address, 32'h24);
        ret(); check("ovf_ret4", IM_address, 32'h14);
        check("ovf_und_clear", {31'd0, ras_underflow}, 32'd0);

        do_reset();
        redir(32'h40); call(32'h20);
        for (int i = 0; i < 3; i++) step(3'd3, 32'h100, 0, 0, 0, 1'b0);
        check("hold_pc", IM_address, 32'h60);
        check("hold_cnt", {29'd0, ras_count}, 32'd1);
        redir(32'h203); check("mis_pc", IM_address, 32'h200);
        check("mis_flag", {31'd0, misalign}, 32'd1);
        step(3'd2, 32'h6, 0, 0, 0, 1'b1); check("jump_mis_pc", IM_address, 32'h204);
        do_reset();
        check("rst2_pc", IM_address, 32'h0);
        check("rst2_flags", {28'd0, ras_count == 0, ras_overflow, ras_underflow, misalign}, 32'h8);

        redir(32'hFFFF_FFFC); seq();
        check("wrap_pc", IM_address, 32'h0);
        check("wrap_flags", {29'd0, ras_overflow, ras_underflow, misalign}, 32'd0);

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
